// File: rtl/zap_wb_desc_responder_pkg.sv
// Shared types and address decode for the descriptor responder.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package zap_wb_resp_pkg;

  localparam int ZAP_WB_RESP_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_resp_state_t;

  // True when the byte address falls inside [base, base + depth*4).
  // Subtracting first keeps the test correct even if base+span would wrap.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int          depth);
    logic [31:0] span;
    span = 32'(depth) << 2;
    return (adr >= base) && ((adr - base) < span);
  endfunction

endpackage

// File: rtl/zap_wb_desc_responder_if.sv
// Wishbone classic bus bundle between fabric (master) and responder (slave).
// Latency: none (wires only).
// Backpressure: the slave terminates each cycle with a single ack or err pulse.
interface zap_wb_desc_responder_if;
  logic        cyc;
  logic        stb;
  logic        wen;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, wen, adr, sel, wdat,
                  input  rdat, ack, err);

  modport slave  (input  cyc, stb, wen, adr, sel, wdat,
                  output rdat, ack, err);
endinterface

// File: rtl/zap_wb_desc_responder_ram.sv
// Single-port descriptor word RAM with per-byte write enables.
// Latency: write commits at the clock edge, read data is combinational.
// Backpressure: none; the owner arbitrates the single port.
module zap_wb_resp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/zap_wb_desc_responder.sv
// Wishbone classic responder serving descriptor reads/writes from a windowed RAM.
// Latency: ack/err high in the cycle WAIT_STATES+1 after the capturing edge.
// Backpressure: one request in flight; the load port only wins when the bus is idle.
module zap_wb_desc_responder
  import zap_wb_resp_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  zap_wb_desc_responder_if.slave   wb,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [31:0]              i_ld_data,
  output logic                     o_ld_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ZAP_WB_RESP_CNT_W-1:0] WS = ZAP_WB_RESP_CNT_W'(WAIT_STATES);

  wb_resp_state_t               state;
  logic [ZAP_WB_RESP_CNT_W-1:0] cnt;
  logic [AW-1:0]                idx_q;
  logic                         wen_q;
  logic                         bad_q;
  logic [3:0]                   sel_q;
  logic [31:0]                  dat_q;
  logic                         live_q;
  logic                         ack_q;
  logic                         err_q;
  logic [31:0]                  rdat_q;

  logic          req;
  logic          req_bad;
  logic          cap_bad;
  logic          cap_wen;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   rdat_nxt;

  // Decode the request and steer the single RAM port between bus and load path.
  // The write in RESP is gated by cyc so a master that abandons the cycle leaves
  // the RAM untouched; ack_q is only set there when the access is legal.
  always_comb begin
    req      = wb.cyc & wb.stb;
    req_bad  = !in_window(wb.adr, BASE_ADDR, DEPTH) || (wb.adr[1:0] != 2'b00);
    o_ld_rdy = live_q && (state == IDLE) && !req && i_ld_en;

    ram_addr  = idx_q;
    ram_we    = 4'h0;
    ram_wdata = dat_q;
    case (state)
      IDLE: begin
        if (req) begin
          ram_addr = wb.adr[AW+1:2];
        end else if (o_ld_rdy) begin
          ram_addr  = i_ld_addr;
          ram_we    = 4'hF;
          ram_wdata = i_ld_data;
        end
      end
      RESP: begin
        if (wb.cyc && ack_q && wen_q) ram_we = sel_q;
      end
      default: ;
    endcase

    // Response data is sampled on the edge that enters RESP; nothing else can
    // write the RAM between capture and RESP, so it equals the RESP-cycle word.
    cap_bad  = (state == IDLE) ? req_bad : bad_q;
    cap_wen  = (state == IDLE) ? wb.wen  : wen_q;
    rdat_nxt = (!cap_bad && !cap_wen) ? ram_rdata : 32'h0;
  end

  // Request FSM with registered ack/err/data; reset aborts any cycle in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      wen_q  <= 1'b0;
      bad_q  <= 1'b0;
      sel_q  <= 4'h0;
      dat_q  <= 32'h0;
      live_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= 32'h0;
    end else begin
      live_q <= 1'b1;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= 32'h0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q <= wb.adr[AW+1:2];
            wen_q <= wb.wen;
            bad_q <= req_bad;
            sel_q <= wb.sel;
            dat_q <= wb.wdat;
            if (WS == '0) begin
              state  <= RESP;
              cnt    <= '0;
              ack_q  <= !cap_bad;
              err_q  <= cap_bad;
              rdat_q <= rdat_nxt;
            end else begin
              state <= WAIT;
              cnt   <= WS;
            end
          end
        end
        WAIT: begin
          if (!wb.cyc) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == ZAP_WB_RESP_CNT_W'(1)) begin
              state  <= RESP;
              ack_q  <= !cap_bad;
              err_q  <= cap_bad;
              rdat_q <= rdat_nxt;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign wb.ack  = ack_q;
  assign wb.err  = err_q;
  assign wb.rdat = rdat_q;

  zap_wb_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_zap_wb_desc_responder.sv
// Bench for the descriptor responder: three instances with 1, 3 and 0 wait states.
// Expected responses are queued as requests are issued and compared on arrival.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_zap_wb_desc_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
    bit          pulse;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc     [3];
  logic        stb     [3];
  logic        wen     [3];
  logic [31:0] adr     [3];
  logic [3:0]  sel     [3];
  logic [31:0] wdat    [3];
  logic [31:0] rdat    [3];
  logic        ack     [3];
  logic        err     [3];
  logic        ld_en   [3];
  logic [3:0]  ld_addr [3];
  logic [31:0] ld_data [3];
  logic        ld_rdy  [3];

  rsp_t sb  [$];
  rsp_t got [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    zap_wb_desc_responder_if bus ();
    assign bus.cyc  = cyc[g];
    assign bus.stb  = stb[g];
    assign bus.wen  = wen[g];
    assign bus.adr  = adr[g];
    assign bus.sel  = sel[g];
    assign bus.wdat = wdat[g];
    assign rdat[g]  = bus.rdat;
    assign ack[g]   = bus.ack;
    assign err[g]   = bus.err;

    zap_wb_desc_responder #(
      .DEPTH       (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) dut (
      .i_clk     (clk),
      .i_reset   (rst_n),
      .wb        (bus.slave),
      .i_ld_en   (ld_en[g]),
      .i_ld_addr (ld_addr[g]),
      .i_ld_data (ld_data[g]),
      .o_ld_rdy  (ld_rdy[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  // Expected response for instance d: ack/err, read data, latency in falling edges.
  function automatic rsp_t exp_rsp(input int d, input logic a, input logic e,
                                   input logic [31:0] dt);
    rsp_t r;
    r.ack = a; r.err = e; r.dat = dt; r.lat = ws_of(d) + 2; r.pulse = 1'b1;
    return r;
  endfunction

  // Issue one bus request from the current point (just after a rising edge) and
  // collect the response. keep=1 leaves cyc/stb asserted for a back-to-back follow-up.
  task automatic do_req(input int d, input bit wr, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input bit keep,
                        output rsp_t o, output bit ld_seen);
    bit done;
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = wr; adr[d] = a; sel[d] = s; wdat[d] = wd;
    o.ack = 1'b0; o.err = 1'b0; o.dat = 32'h0; o.lat = -1; o.pulse = 1'b1;
    ld_seen = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (ld_rdy[d]) ld_seen = 1'b1;
      if (ack[d] || err[d]) begin
        o.ack = ack[d]; o.err = err[d]; o.dat = rdat[d]; o.lat = k; done = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (!keep) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0;
      @(negedge clk);
      o.pulse = !(ack[d] || err[d]);
      @(posedge clk); #1;
    end
  endtask

  task automatic load_word(input int d, input logic [3:0] a, input logic [31:0] v,
                           output bit ok);
    ok = 1'b0;
    ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (ld_rdy[d]) ok = 1'b1;
    end
    @(posedge clk); #1;
    ld_en[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 0; stb[d] = 0; wen[d] = 0; adr[d] = 0; sel[d] = 0; wdat[d] = 0;
      ld_en[d] = 1'b1; ld_addr[d] = 4'd0; ld_data[d] = 32'h0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({ack[d], err[d], rdat[d], ld_rdy[d]} !== 35'h0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: ack=%b err=%b dat=%h ld_rdy=%b, want all 0",
                 d, ack[d], err[d], rdat[d], ld_rdy[d]);
      end
      ld_en[d] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_read();
    rsp_t o, e, g;
    bit ok, ls;
    int nok = 0;
    logic [31:0] words [4];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        load_word(d, 4'(i), words[i], ok);
        if (ok) nok++;
      end
    n_cmp++;
    if (nok !== 12) begin
      n_bad++;
      $display("FAIL load_accept: %0d loads accepted, want 12", nok);
    end
    sb.push_back(exp_rsp(0, 1, 0, 32'h3333_3333)); do_req(0, 0, 32'h4008, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h1111_1111)); do_req(0, 0, 32'h4000, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h4444_4444)); do_req(0, 0, 32'h400C, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(1, 1, 0, 32'h2222_2222)); do_req(1, 0, 32'h4004, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(2, 1, 0, 32'h3333_3333)); do_req(2, 0, 32'h4008, 4'h0, 0, 0, o, ls); got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL load_read: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  task automatic test_byte_write();
    rsp_t o, e, g;
    bit ls;
    sb.push_back(exp_rsp(0, 1, 0, 32'h0));         do_req(0, 1, 32'h4004, 4'b0101, 32'hAABB_CCDD, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h22BB_22DD)); do_req(0, 0, 32'h4004, 4'h0, 0, 0, o, ls);                got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h0));         do_req(0, 1, 32'h4008, 4'b0000, 32'hFFFF_FFFF, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h3333_3333)); do_req(0, 0, 32'h4008, 4'h0, 0, 0, o, ls);                got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h0));         do_req(0, 1, 32'h400C, 4'b1000, 32'h9900_0000, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h9944_4444)); do_req(0, 0, 32'h400C, 4'h0, 0, 0, o, ls);                got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL byte_write: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  task automatic test_errors();
    rsp_t o, e, g;
    bit ls;
    sb.push_back(exp_rsp(0, 0, 1, 32'h0)); do_req(0, 0, 32'h3FFC, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 0, 1, 32'h0)); do_req(0, 0, BASE + 32'(DEPTH * 4), 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 0, 1, 32'h0)); do_req(0, 0, 32'h4002, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(2, 0, 1, 32'h0)); do_req(2, 0, 32'h3FFC, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 0, 1, 32'h0)); do_req(0, 1, 32'h4001, 4'hF, 32'h0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(0, 1, 0, 32'h1111_1111)); do_req(0, 0, 32'h4000, 4'h0, 0, 0, o, ls); got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL errors: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t o, e, g;
    bit ls;
    bit any_ld = 1'b0;
    int pulses = 0;
    ld_en[0] = 1'b1; ld_addr[0] = 4'd5; ld_data[0] = 32'h5555_5555;
    sb.push_back(exp_rsp(0, 1, 0, 32'h1111_1111)); do_req(0, 0, 32'h4000, 4'h0, 0, 1, o, ls); got.push_back(o); any_ld |= ls;
    sb.push_back(exp_rsp(0, 1, 0, 32'h22BB_22DD)); do_req(0, 0, 32'h4004, 4'h0, 0, 1, o, ls); got.push_back(o); any_ld |= ls;
    sb.push_back(exp_rsp(0, 1, 0, 32'h3333_3333)); do_req(0, 0, 32'h4008, 4'h0, 0, 1, o, ls); got.push_back(o); any_ld |= ls;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ld_rdy[0]) pulses++;
      @(posedge clk); #1;
      if (pulses > 0) ld_en[0] = 1'b0;
    end
    n_cmp++;
    if (any_ld !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ld_blocked: ld_rdy seen=%b during bus traffic, want 0", any_ld);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL b2b_ld_pulse: ld_rdy pulses=%0d after stb drop, want 1", pulses);
    end
    sb.push_back(exp_rsp(0, 1, 0, 32'h5555_5555)); do_req(0, 0, 32'h4014, 4'h0, 0, 0, o, ls); got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL back_to_back: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  task automatic test_abort();
    rsp_t o, e, g;
    bit ls;
    bit seen = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b1;
    adr[1] = 32'h4000; sel[1] = 4'hF; wdat[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; wen[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack[1] || err[1]) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_resp: ack/err seen=%b after cyc drop in WAIT, want 0", seen);
    end
    sb.push_back(exp_rsp(1, 1, 0, 32'h1111_1111)); do_req(1, 0, 32'h4000, 4'h0, 0, 0, o, ls); got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL abort_readback: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  task automatic test_reset_in_resp();
    rsp_t o, e, g;
    bit ls;
    cyc[2] = 1'b1; stb[2] = 1'b1; wen[2] = 1'b1;
    adr[2] = 32'h4004; sel[2] = 4'hF; wdat[2] = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ack[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_resp_ack: ack=%b in RESP before reset, want 1", ack[2]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack[2], err[2], rdat[2], ld_rdy[2]} !== 35'h0) begin
      n_bad++;
      $display("FAIL rst_resp_async: ack=%b err=%b dat=%h ld_rdy=%b, want all 0",
               ack[2], err[2], rdat[2], ld_rdy[2]);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0; wen[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(exp_rsp(2, 1, 0, 32'h2222_2222)); do_req(2, 0, 32'h4004, 4'h0, 0, 0, o, ls); got.push_back(o);
    sb.push_back(exp_rsp(2, 1, 0, 32'h1111_1111)); do_req(2, 0, 32'h4000, 4'h0, 0, 0, o, ls); got.push_back(o);
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_cmp++;
      if ({g.ack, g.err, g.dat, g.pulse} !== {e.ack, e.err, e.dat, e.pulse} || g.lat != e.lat) begin
        n_bad++;
        $display("FAIL rst_resp_read: got ack=%b err=%b dat=%h lat=%0d pulse=%b, want ack=%b err=%b dat=%h lat=%0d pulse=%b",
                 g.ack, g.err, g.dat, g.lat, g.pulse, e.ack, e.err, e.dat, e.lat, e.pulse);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_read();
    test_byte_write();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
